fifo_push_arb: RTL

//   Round-robin, burst-aware arbiter that shares the single push port of one

---
 rtl/fifo_pkg.sv | 15 +
 rtl/rr_arb_pick.sv | 34 +++
 rtl/fifo_push_arb.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO push/pop schedulers.
// Holds the arbiter state encoding and the modulo round-robin increment.
package fifo_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Wraps at n, so non-power-of-2 requester counts rotate correctly.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr, wrapping.
// Falls back to rr_ptr when no requester is valid.
module rr_arb_pick #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [IDW-1:0]   pick,
    output logic             any_valid
);

    // Scan offsets from far to near so the nearest valid candidate wins.
    always_comb begin
        int unsigned cand;
        logic [IDW-1:0] cand_idx;
        pick      = rr_ptr;
        any_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = 32'(rr_ptr) + 32'(k);
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDW'(cand);
            if (valid[cand_idx]) begin
                pick      = cand_idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// Burst-aware round-robin arbiter sharing one sync_fifo push port among N_REQ requesters.
// Define FIFO_PUSH_ARB_TAG_EN to prepend the grant index to each pushed payload.
module fifo_push_arb
    import fifo_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = $clog2(N_REQ),
    localparam int CW        = $clog2(MAX_BURST + 1),
`ifdef FIFO_PUSH_ARB_TAG_EN
    localparam int DW        = WIDTH + IDW
`else
    localparam int DW        = WIDTH
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    input  logic                   fifo_full_i,
    output logic                   fifo_push_o,
    output logic [DW-1:0]          fifo_data_o,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   busy_o
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0] pick;
    logic           any_valid;
    logic           owner_valid;
    logic           burst_done;
    logic [IDW-1:0] grant;
    logic [WIDTH-1:0] payload;

    rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .valid     (req_valid_i),
        .rr_ptr    (rr_ptr_q),
        .pick      (pick),
        .any_valid (any_valid)
    );

    assign owner_valid = req_valid_i[owner_q];
    // A full burst is retired in the following cycle, which is the bubble between grants.
    assign burst_done  = (beat_cnt_q == CW'(MAX_BURST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid && !fifo_full_i) begin
                    owner_d = pick;
                    if (MAX_BURST == 1) begin
                        rr_ptr_d   = IDW'(rr_next(32'(pick), N_REQ));
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = CW'(1);
                        state_d    = ARB_BURST;
                    end
                end
            end
            ARB_BURST: begin
                if (!owner_valid || burst_done) begin
                    state_d    = ARB_IDLE;
                    rr_ptr_d   = IDW'(rr_next(32'(owner_q), N_REQ));
                    beat_cnt_d = '0;
                end else if (!fifo_full_i) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        req_ready_o = '0;
        grant       = rr_ptr_q;
        busy_o      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant = pick;
                if (any_valid && !fifo_full_i) begin
                    req_ready_o[pick] = 1'b1;
                end
            end
            ARB_BURST: begin
                grant  = owner_q;
                busy_o = 1'b1;
                if (owner_valid && !fifo_full_i && !burst_done) begin
                    req_ready_o[owner_q] = 1'b1;
                end
            end
            default: ;
        endcase
        if (!rst_ni) begin
            req_ready_o = '0;
            grant       = '0;
            busy_o      = 1'b0;
        end

        payload = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant == IDW'(k)) begin
                payload = req_data_i[k*WIDTH +: WIDTH];
            end
        end
        if (!rst_ni) begin
            payload = '0;
        end

        grant_id_o  = grant;
        fifo_push_o = |(req_valid_i & req_ready_o);
`ifdef FIFO_PUSH_ARB_TAG_EN
        fifo_data_o = {grant, payload};
`else
        fifo_data_o = payload;
`endif
    end

endmodule
